// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between the in-order
//            pipeline write-back and an out-of-band multiply/divide unit.
//            The pipeline wins by default. A losing mul/div result is parked
//            in a one-entry buffer. A starvation counter forces a one-cycle
//            pipeline freeze so the parked result always retires.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic              md_valid,
  input  logic [DATA_W-1:0] md_data,
  input  logic [ADDR_W-1:0] md_dest,
  output logic              md_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pipe_stall,
  output logic              grant_md
);

  // Counter is wide enough to hold STARVE_LIMIT itself and saturates there.
  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  C_LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  C_ONE      = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_ZERO_REG = '0;

  // The buffer is valid exactly when the state is HOLD or FORCE, so no
  // separate valid flop is kept.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   buf_dest_q, buf_dest_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                grant_md_q, grant_md_d;

  logic                w_pipe_wr;
  logic                w_md_xfer;
  logic                w_md_live;

  // Handshake and stall are pure state decodes so they never depend on
  // same-cycle inputs.
  assign md_ready   = (state_q == S_IDLE);
  assign pipe_stall = (state_q == S_FORCE);

  // A pipeline entry seen during the freeze is re-presented next cycle, so it
  // is not an effective write now. Writes to r0 are never real writes.
  assign w_pipe_wr  = wb_reg_write && (wb_dest != C_ZERO_REG) && !pipe_stall;
  assign w_md_xfer  = md_valid && md_ready;
  // A transferred result targeting r0 is consumed but has nothing to write.
  assign w_md_live  = w_md_xfer && (md_dest != C_ZERO_REG);

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_md = grant_md_q;

  // Next-state, buffer and write-port decision for the coming edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_dest_d = buf_dest_q;
    buf_data_d = buf_data_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    grant_md_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_pipe_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = wb_dest;
          rf_wdata_d = wb_data;
          // The pipeline is younger: a same-dest mul/div result is stale and
          // simply dropped; otherwise it waits in the buffer.
          if (w_md_live && (md_dest != wb_dest)) begin
            buf_dest_d = md_dest;
            buf_data_d = md_data;
            cnt_d      = C_ONE;
            state_d    = S_HOLD;
          end
        end else if (w_md_live) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = md_dest;
          rf_wdata_d = md_data;
          grant_md_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (!w_pipe_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = buf_dest_q;
          rf_wdata_d = buf_data_q;
          grant_md_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else if (wb_dest == buf_dest_q) begin
          // Younger pipeline write supersedes the parked result.
          rf_we_d    = 1'b1;
          rf_waddr_d = wb_dest;
          rf_wdata_d = wb_data;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = wb_dest;
          rf_wdata_d = wb_data;
          if (cnt_q >= (C_LIMIT - C_ONE)) begin
            cnt_d   = C_LIMIT;
            state_d = S_FORCE;
          end else begin
            cnt_d   = cnt_q + C_ONE;
          end
        end
      end

      S_FORCE: begin
        // Pipeline is frozen this cycle, so the buffer owns the port.
        rf_we_d    = 1'b1;
        rf_waddr_d = buf_dest_q;
        rf_wdata_d = buf_data_q;
        grant_md_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, buffer and registered write-port outputs; reset drops any buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      buf_dest_q <= '0;
      buf_data_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_md_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_dest_q <= buf_dest_d;
      buf_data_q <= buf_data_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_md_q <= grant_md_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter (STARVE_LIMIT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wb_reg_write = 1'b0;
  logic [DATA_W-1:0] wb_data = '0;
  logic [ADDR_W-1:0] wb_dest = '0;
  logic              md_valid = 1'b0;
  logic [DATA_W-1:0] md_data = '0;
  logic [ADDR_W-1:0] md_dest = '0;
  logic              md_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pipe_stall;
  logic              grant_md;

  wb_port_arbiter #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .md_valid     (md_valid),
    .md_data      (md_data),
    .md_dest      (md_dest),
    .md_ready     (md_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pipe_stall   (pipe_stall),
    .grant_md     (grant_md)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [37:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic expect_wr(input int at, input logic g, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    exp_t e;
    e.at  = at;
    e.val = {g, a, d};
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic wv, input logic [ADDR_W-1:0] wd, input logic [DATA_W-1:0] wdat,
                       input logic mv, input logic [ADDR_W-1:0] mdd, input logic [DATA_W-1:0] mdat);
    @(negedge clk);
    wb_reg_write = wv;
    wb_dest      = wd;
    wb_data      = wdat;
    md_valid     = mv;
    md_dest      = mdd;
    md_data      = mdat;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Scoreboard: every rf write must match the oldest expectation in cycle and value.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      check("missing_wr_cyc", 64'(cyc), 64'(e.at));
    end
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {63'b0, rf_we}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_cyc", 64'(cyc), 64'(e.at));
        check("wr_val", {26'b0, grant_md, rf_waddr, rf_wdata}, {26'b0, e.val});
      end
    end
  end

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_we",    {63'b0, rf_we},      64'd0);
    check("rst_waddr", {59'b0, rf_waddr},   64'd0);
    check("rst_wdata", {32'b0, rf_wdata},   64'd0);
    check("rst_grant", {63'b0, grant_md},   64'd0);
    check("rst_ready", {63'b0, md_ready},   64'd1);
    check("rst_stall", {63'b0, pipe_stall}, 64'd0);

    // Lone mul/div result
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
    check("lone_ready", {63'b0, md_ready}, 64'd1);
    expect_wr(cyc + 1, 1'b1, 5'd7, 32'h1234);
    idle(1);
    check("lone_ready_after", {63'b0, md_ready}, 64'd1);
    idle(2);

    // Collision with different dests
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
    expect_wr(cyc + 1, 1'b0, 5'd3, 32'hAAAA);
    expect_wr(cyc + 2, 1'b1, 5'd5, 32'hBBBB);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'hDEAD);
    check("coll_ready_low", {63'b0, md_ready}, 64'd0);
    idle(1);
    check("coll_ready_back", {63'b0, md_ready}, 64'd1);
    idle(2);

    // Starvation: four pipeline wins then one forced freeze
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
    expect_wr(cyc + 1, 1'b0, 5'd1, 32'h1);
    for (int i = 2; i <= STARVE_LIMIT; i++) begin
      drive(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'h0);
      check("starve_hold_ready", {63'b0, md_ready},   64'd0);
      check("starve_hold_stall", {63'b0, pipe_stall}, 64'd0);
      expect_wr(cyc + 1, 1'b0, 5'(i), 32'(i));
    end
    drive(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'h0);
    check("force_stall", {63'b0, pipe_stall}, 64'd1);
    check("force_ready", {63'b0, md_ready},   64'd0);
    expect_wr(cyc + 1, 1'b1, 5'd9, 32'h99);
    drive(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'h0);
    check("force_stall_once", {63'b0, pipe_stall}, 64'd0);
    check("force_ready_back", {63'b0, md_ready},   64'd1);
    expect_wr(cyc + 1, 1'b0, 5'd5, 32'h5);
    idle(3);

    // Buffered result superseded by same-dest pipeline write
    drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd6, 32'h1);
    expect_wr(cyc + 1, 1'b0, 5'd10, 32'h10);
    drive(1'b1, 5'd6, 32'h2, 1'b0, 5'd0, 32'h0);
    check("drop_hold_ready", {63'b0, md_ready}, 64'd0);
    expect_wr(cyc + 1, 1'b0, 5'd6, 32'h2);
    idle(1);
    check("drop_ready_back", {63'b0, md_ready},   64'd1);
    check("drop_stall",      {63'b0, pipe_stall}, 64'd0);
    idle(3);

    // Same-cycle same-dest: only the pipeline write survives
    drive(1'b1, 5'd11, 32'h3, 1'b1, 5'd11, 32'h4);
    expect_wr(cyc + 1, 1'b0, 5'd11, 32'h3);
    idle(1);
    check("same_dest_ready", {63'b0, md_ready}, 64'd1);
    idle(2);

    // Zero register handling
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    idle(1);
    check("zero_wb_we", {63'b0, rf_we}, 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBEEF);
    check("zero_md_ready", {63'b0, md_ready}, 64'd1);
    idle(1);
    check("zero_md_we",    {63'b0, rf_we},    64'd0);
    check("zero_md_ready_after", {63'b0, md_ready}, 64'd1);
    drive(1'b1, 5'd12, 32'hC, 1'b1, 5'd0, 32'hF);
    expect_wr(cyc + 1, 1'b0, 5'd12, 32'hC);
    idle(1);
    check("zero_md_coll_ready", {63'b0, md_ready}, 64'd1);
    idle(2);

    // Reset while a result is buffered
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'h88);
    expect_wr(cyc + 1, 1'b0, 5'd2, 32'h22);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    check("rsthold_ready_low", {63'b0, md_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rsthold_we",    {63'b0, rf_we},      64'd0);
    check("rsthold_ready", {63'b0, md_ready},   64'd1);
    check("rsthold_stall", {63'b0, pipe_stall}, 64'd0);
    idle(6);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register-file write port between the in-order pipeline write-back (fed by the MEM/WB pipeline register outputs) and a long-latency multiply/divide unit that completes out of band. The pipeline has priority; an accepted multiply/divide result waits in a one-entry buffer. A starvation counter forces a one-cycle pipeline freeze so the buffered result is guaranteed to retire. All register-file write outputs are registered, and the block sits between the WB stage and the register file write port.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- STARVE_LIMIT, 4, consecutive pipeline wins tolerated while a result is buffered (must be ≥1)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- wb_reg_write  in  1  pipeline write request (from MEM/WB)
- wb_data  in  DATA_W  pipeline write data
- wb_dest  in  ADDR_W  pipeline destination register
- md_valid  in  1  mul/div result valid
- md_data  in  DATA_W  mul/div result data
- md_dest  in  ADDR_W  mul/div destination register
- md_ready  out  1  arbiter can accept a mul/div result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- pipe_stall  out  1  freeze MEM/WB and earlier stages this cycle
- grant_md  out  1  registered; 1 = the current rf write came from mul/div

## Operation
- Effective pipeline write:
  - P = wb_reg_write && wb_dest != 0 && !pipe_stall.
  - A pipeline entry presented while pipe_stall=1 is ignored; the frozen MEM/WB re-presents it next cycle.
- Mul/div handshake:
  - A transfer occurs on a cycle with md_valid && md_ready.
  - A transferred result with md_dest=0 is accepted and discarded.
- The pipeline is always the younger producer. A buffered or incoming mul/div result whose dest equals a same-cycle P write dest is dropped.
- States: IDLE, HOLD, FORCE.
  - md_ready = (state==IDLE).
  - pipe_stall = (state==FORCE).
  - Both are decoded from state only.
- IDLE:
  - transfer && !P → write md directly; stay IDLE.
  - transfer && P, dests differ → write pipe; capture md into buffer; cnt=1; go HOLD.
  - transfer && P, same dest → write pipe; drop md; stay IDLE.
  - no transfer → write pipe if P, else rf_we=0.
- HOLD:
  - !P → write buffer; cnt=0; go IDLE.
  - P, dest == buffer dest → write pipe; drop buffer; cnt=0; go IDLE.
  - P, dest differs → write pipe; cnt++. If cnt reaches STARVE_LIMIT, go FORCE.
- FORCE: write buffer unconditionally; cnt=0; go IDLE.
- Counter width is $clog2(STARVE_LIMIT+1); it never wraps.

## Timing
- Reset values: state=IDLE, buffer invalid, cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, grant_md=0. This gives md_ready=1 and pipe_stall=0 from the first cycle after reset.
- Reset mid-HOLD/FORCE discards the buffered result without writing it. rst has priority over all inputs.
- Latency: the decision is made at edge N; rf_we/rf_waddr/rf_wdata/grant_md are valid for cycle N+1.
- rf_we is a single-cycle pulse per write. At most one write per cycle.
- Worst-case latency for a mul/div result, from transfer to rf write, is STARVE_LIMIT+1 cycles.
- pipe_stall is high for exactly one cycle per FORCE entry and never in consecutive cycles. md_ready is low in that same cycle.

## Test plan
- Lone mul/div: md_valid=1, md_dest=7, md_data=0x1234, no pipeline write → next cycle rf_we=1, rf_waddr=7, rf_wdata=0x1234, grant_md=1; md_ready stays 1.
- Collision: pipeline writes r3=0xAAAA while md delivers r5=0xBBBB → cycle+1 writes r3; cycle+2 writes r5 with grant_md=1; md_ready low for exactly one cycle.
- Starvation, STARVE_LIMIT=4: md r9 buffered while the pipeline writes r1..r4 on consecutive cycles → pipe_stall=1 for one cycle; r9 written the next cycle; the held pipeline entry is written afterwards, none lost or duplicated.
- Same-dest drop: buffered md r6=0x1, pipeline writes r6=0x2 → only r6=0x2 is written; state returns to IDLE; md_ready=1.
- Zero register: pipeline wb_dest=0 with wb_reg_write=1 → rf_we=0. md_dest=0 → accepted (md_ready=1) and never written.
- Reset in HOLD: buffer r8, assert rst for one cycle → rf_we=0, md_ready=1, pipe_stall=0; r8 never written.
